// File: rtl/tt_dfd_fifo_mn_drain_pkg.sv
// Shared types for the multi-port FIFO drain block.
`default_nettype none

package tt_dfd_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

endpackage

`default_nettype wire

// File: rtl/tt_dfd_fifo_mn_drain_if.sv
// FIFO-side and output-side handshake bundle of the drain block.
`default_nettype none

interface tt_dfd_fifo_mn_drain_if #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_RD     = 2,
  parameter int CNT_W      = 4
);

  logic [CNT_W-1:0]                   fifo_cnt;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]  fifo_data;
  logic [NUM_RD-1:0]                  fifo_pop;
  logic                               valid;
  logic                               ready;
  logic [NUM_RD*DATA_WIDTH-1:0]       data;
  logic [NUM_RD-1:0]                  mask;

  modport master (
    input  fifo_cnt, fifo_data, ready,
    output fifo_pop, valid, data, mask
  );

  modport slave (
    output fifo_cnt, fifo_data, ready,
    input  fifo_pop, valid, data, mask
  );

endinterface

`default_nettype wire

// File: rtl/tt_dfd_fifo_mn_drain_timer.sv
// Saturating partial-group timeout counter; limit of zero never expires.
`default_nettype none

module tt_dfd_drain_timer #(
  parameter int TMO_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [TMO_W-1:0] limit_i,
  output logic             expired_o
);

  logic [TMO_W-1:0] count_q;
  logic [TMO_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (limit_i != '0) && (count_q == limit_i);

endmodule

`default_nettype wire

// File: rtl/tt_dfd_fifo_mn_drain.sv
// tt_dfd_fifo_mn_drain: groups NUM_RD FIFO entries per output beat, with
// timeout/flush draining of partial groups. Rev 1.0
`default_nettype none

module tt_dfd_fifo_mn_drain
  import tt_dfd_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ENTRIES    = 8,
  parameter int NUM_RD     = 2,
  parameter int CNT_W      = $clog2(ENTRIES) + 1,
  parameter int TMO_W      = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  tt_dfd_fifo_mn_drain_if.master  bus,
  input  logic                    i_enable,
  input  logic                    i_flush,
  input  logic [TMO_W-1:0]        i_timeout,
  output logic                    o_flush_done
);

  localparam int KW = $clog2(NUM_RD + 1);

  drain_state_e                 state_q, state_d;
  logic                         valid_q, valid_d;
  logic [NUM_RD*DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_RD-1:0]            mask_q, mask_d;

  logic              free;
  logic              flush_pend;
  logic              expired;
  logic              cnt_full;
  logic              cnt_partial;
  logic              pop_ok;
  logic              pop_fire;
  logic              empties;
  logic              timer_clr;
  logic              timer_inc;
  logic [KW-1:0]     k;
  logic [NUM_RD-1:0] pop;

  assign free        = !valid_q || bus.ready;
  assign flush_pend  = (state_q == FLUSH);
  // An illegal over-range count is treated as a full group.
  assign cnt_full    = (int'(bus.fifo_cnt) >= NUM_RD) || (int'(bus.fifo_cnt) > ENTRIES);
  assign cnt_partial = (bus.fifo_cnt != '0) && !cnt_full;
  assign pop_ok      = !i_reset && free && (i_enable || flush_pend);

  always_comb begin
    k = '0;
    if (cnt_full) begin
      k = KW'(NUM_RD);
    end else if (cnt_partial && (expired || flush_pend)) begin
      k = KW'(bus.fifo_cnt);
    end
  end

  always_comb begin
    pop = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      pop[j] = pop_ok && (j < int'(k));
    end
  end

  assign pop_fire = |pop;
  assign empties  = pop_fire && !(int'(bus.fifo_cnt) > ENTRIES) &&
                    (int'(bus.fifo_cnt) == int'(k));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_flush) begin
          state_d = FLUSH;
        end else if (cnt_partial) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (i_flush) begin
          state_d = FLUSH;
        end else if (empties || (bus.fifo_cnt == '0)) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        // Completion wins over a repeated flush request, which is absorbed.
        if ((bus.fifo_cnt == '0) && !valid_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_flush_done = !i_reset && flush_pend && (bus.fifo_cnt == '0) && !valid_q;

  assign timer_clr = pop_fire || (state_q != ACCUM) || (state_d != ACCUM);
  assign timer_inc = (state_q == ACCUM) && free && i_enable;

  tt_dfd_drain_timer #(
    .TMO_W (TMO_W)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .clear_i   (timer_clr),
    .inc_i     (timer_inc),
    .limit_i   (i_timeout),
    .expired_o (expired)
  );

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    mask_d  = mask_q;
    if (pop_fire) begin
      valid_d = 1'b1;
      mask_d  = pop;
      for (int j = 0; j < NUM_RD; j++) begin
        data_d[j*DATA_WIDTH +: DATA_WIDTH] = pop[j] ? bus.fifo_data[j] : '0;
      end
    end else if (bus.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.fifo_pop = pop;
  assign bus.valid    = valid_q;
  assign bus.data     = data_q;
  assign bus.mask     = mask_q;

endmodule

`default_nettype wire
